// File: rtl/instruction_buffer.sv
// instruction_buffer: first-word-fall-through FIFO of decoded local instructions
// sitting between the decoder and the compute-unit issue stage. Flush empties
// the buffer in one cycle and takes priority over any push or pop.
module instruction_buffer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_opcode,
    input  logic [3:0]       in_target_reg,
    input  logic [3:0]       in_address_reg,
    input  logic [3:0]       in_imm_short,
    input  logic [1:0]       in_array_id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_opcode,
    output logic [3:0]       out_target_reg,
    output logic [3:0]       out_address_reg,
    output logic [3:0]       out_imm_short,
    output logic [1:0]       out_array_id,
    input  logic             flush,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = 18;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] head;

    // Status flags come straight from the occupancy count; in_ready ignores
    // out_ready, so a full buffer never accepts even while it is popping.
    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage array is deliberately left unreset; only pointers carry state.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= {in_opcode, in_target_reg, in_address_reg,
                            in_imm_short, in_array_id};
        end
    end

    // Pointer and occupancy bookkeeping; flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Head entry falls through to the outputs, zeroed whenever the buffer is empty.
    assign head = mem[rd_ptr];
    assign {out_opcode, out_target_reg, out_address_reg, out_imm_short, out_array_id} =
        out_valid ? head : '0;

`ifndef SYNTHESIS
    // Occupancy can never exceed the number of storage entries.
    count_in_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CNT_W'(DEPTH));

    // A stalled upstream instruction must be held steady until it is accepted.
    stalled_input_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (in_valid && !in_ready) |=> (!in_valid ||
            $stable({in_opcode, in_target_reg, in_address_reg, in_imm_short, in_array_id})));
`endif

endmodule
